tx_frame_arbiter: RTL and testbench

Shares the single FPGA→Host proto245 TX FIFO between several internal requesters, such as status readback, error reporting and calibration acknowledgements. Each requester presents a 16-bit code and a 32-bit payload. A round-robin arbiter picks one requester, and a framer serialises the request into the 8-byte host frame `0xAA, code, data, 0x55`. The block sits beside the host-command receiver and exclusively drives `txfifo_wr`/`txfifo_data`.

---
 rtl/tx_frame_arbiter_if.sv | 28 ++
 rtl/tx_frame_arbiter.sv | 125 ++++++++++++
 tb/tb_tx_frame_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_arbiter_if.sv
// Requester-side and TX-FIFO-side signals of tx_frame_arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface tx_frame_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int TX_FIFO_LOAD_W = 9
);
    logic [NUM_REQ-1:0]        req;
    logic [16*NUM_REQ-1:0]     req_code;
    logic [32*NUM_REQ-1:0]     req_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic                      done;
    logic [15:0]               frame_count;
    logic [TX_FIFO_LOAD_W-1:0] txfifo_load;
    logic                      txfifo_full;
    logic                      txfifo_wr;
    logic [7:0]                txfifo_data;

    modport master (
        input  req, req_code, req_data, txfifo_load, txfifo_full,
        output grant, busy, done, frame_count, txfifo_wr, txfifo_data
    );

    modport slave (
        output req, req_code, req_data, txfifo_load, txfifo_full,
        input  grant, busy, done, frame_count, txfifo_wr, txfifo_data
    );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter plus framer: serialises one requester's code/data into
// the 8-byte host frame AA, code[15:0], data[31:0], 55 on the shared TX FIFO.
module tx_frame_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TX_FIFO_LOAD_W = 9,
    parameter int TX_FIFO_DEPTH  = 256
) (
    input  logic               clk,
    input  logic               rst,
    tx_frame_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [TX_FIFO_LOAD_W-1:0] SPACE_MAX = TX_FIFO_LOAD_W'(TX_FIFO_DEPTH - 8);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_byte_idx;
    logic [15:0]        r_code;
    logic [31:0]        r_data;
    logic [IDX_W-1:0]   r_last;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_done;
    logic [15:0]        r_frame_count;

    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_scan;
    logic               w_space_ok;
    logic               w_start;
    logic               w_wr;
    logic               w_last_write;
    logic [7:0]         w_byte;

    // Scan from the highest offset down so the nearest index after r_last wins.
    always_comb begin
        w_winner = r_last;
        w_scan   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_scan = IDX_W'((int'(r_last) + k) % NUM_REQ);
            if (bus.req[w_scan]) w_winner = w_scan;
        end
    end

    assign w_space_ok = ~bus.txfifo_full && (bus.txfifo_load <= SPACE_MAX);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_wr         = 1'b0;
        w_last_write = 1'b0;
        w_byte       = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (|bus.req && w_space_ok) begin
                    w_start      = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                // rst gates the strobe so the assertion cycle already writes nothing.
                w_wr = ~bus.txfifo_full & ~rst;
                if (w_wr) begin
                    case (r_byte_idx)
                        3'd0: w_byte = 8'hAA;
                        3'd1: w_byte = r_code[15:8];
                        3'd2: w_byte = r_code[7:0];
                        3'd3: w_byte = r_data[31:24];
                        3'd4: w_byte = r_data[23:16];
                        3'd5: w_byte = r_data[15:8];
                        3'd6: w_byte = r_data[7:0];
                        3'd7: w_byte = 8'h55;
                        default: w_byte = 8'h00;
                    endcase
                    if (r_byte_idx == 3'd7) begin
                        w_last_write = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx    <= '0;
            r_code        <= '0;
            r_data        <= '0;
            r_last        <= IDX_W'(NUM_REQ - 1);
            r_grant       <= '0;
            r_done        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_grant       <= w_start ? (NUM_REQ'(1) << w_winner) : '0;
            r_done        <= w_last_write;
            r_frame_count <= r_frame_count + {15'd0, w_last_write};
            if (w_start) begin
                r_last     <= w_winner;
                r_code     <= bus.req_code[16*w_winner +: 16];
                r_data     <= bus.req_data[32*w_winner +: 32];
                r_byte_idx <= '0;
            end else if (w_wr) begin
                r_byte_idx <= r_byte_idx + 3'd1;
            end
        end
    end

    assign bus.grant       = r_grant;
    assign bus.busy        = (r_state == S_SEND);
    assign bus.done        = r_done;
    assign bus.frame_count = r_frame_count;
    assign bus.txfifo_wr   = w_wr;
    assign bus.txfifo_data = w_byte;
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: table-driven arbitration vectors plus
// hand-written multi-cycle sequences; written bytes are checked against a scoreboard.
module tb_tx_frame_arbiter;
    localparam int NUM_REQ = 4;
    localparam int LOAD_W  = 9;
    localparam int DEPTH   = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tx_frame_arbiter_if #(.NUM_REQ(NUM_REQ), .TX_FIFO_LOAD_W(LOAD_W)) bus ();

    tx_frame_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .TX_FIFO_LOAD_W(LOAD_W),
        .TX_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct {
        logic [3:0]  req;
        logic        full;
        logic [8:0]  load;
        logic [15:0] code;
        logic [31:0] data;
        logic [3:0]  exp_grant;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [7:0]  sb[$];
    logic [7:0]  mon_b;
    logic [15:0] exp_fc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [15:0] c, input logic [31:0] d);
        for (int j = 0; j < NUM_REQ; j++) begin
            bus.req_code[16*j +: 16] = c + 16'(j);
            bus.req_data[32*j +: 32] = d + 32'(j);
        end
    endtask

    task automatic push_frame(input logic [15:0] c, input logic [31:0] d, input int n);
        logic [7:0] b[8];
        b = '{8'hAA, c[15:8], c[7:0], d[31:24], d[23:16], d[15:8], d[7:0], 8'h55};
        for (int k = 0; k < n; k++) sb.push_back(b[k]);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            next_cycle();
            n++;
        end
        check("done_seen", 32'(bus.done), 1);
    endtask

    task automatic reset_dut();
        rst             = 1'b1;
        bus.req         = '0;
        bus.req_code    = '0;
        bus.req_data    = '0;
        bus.txfifo_load = '0;
        bus.txfifo_full = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Byte monitor: every write must match the scoreboard head, idle data must be 0.
    always @(negedge clk) begin
        check("grant_onehot", 32'($countones(bus.grant) <= 1), 1);
        if (bus.txfifo_wr) begin
            if (sb.size() == 0) begin
                check("write_expected", 0, 1);
            end else begin
                mon_b = sb.pop_front();
                check("tx_byte", 32'(bus.txfifo_data), 32'(mon_b));
            end
        end else begin
            check("data_zero_no_wr", 32'(bus.txfifo_data), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tab[10];
        int   n;
        int   lane;
        int   w;
        int   last_g;

        tab[0] = '{4'b0001, 1'b0, 9'd0,   16'h0005, 32'hDEADBEEF, 4'b0001};
        tab[1] = '{4'b0110, 1'b0, 9'd100, 16'h1234, 32'h01020304, 4'b0010};
        tab[2] = '{4'b1111, 1'b0, 9'd0,   16'hABCD, 32'hCAFEF00D, 4'b0100};
        tab[3] = '{4'b1011, 1'b0, 9'd0,   16'h0F0F, 32'h80000001, 4'b1000};
        tab[4] = '{4'b1010, 1'b0, 9'd0,   16'hFFFF, 32'hFFFFFFFF, 4'b0010};
        tab[5] = '{4'b1001, 1'b0, 9'd0,   16'h5AA5, 32'h12345678, 4'b1000};
        tab[6] = '{4'b0100, 1'b1, 9'd0,   16'h4444, 32'h44444444, 4'b0000};
        tab[7] = '{4'b0100, 1'b0, 9'd0,   16'h4444, 32'h44444444, 4'b0100};
        tab[8] = '{4'b0010, 1'b0, 9'd249, 16'h7777, 32'h55AA55AA, 4'b0000};
        tab[9] = '{4'b0010, 1'b0, 9'd248, 16'h7777, 32'h55AA55AA, 4'b0010};

        // Reset values, sampled while rst is still high.
        rst             = 1'b1;
        bus.req         = '0;
        bus.req_code    = '0;
        bus.req_data    = '0;
        bus.txfifo_load = '0;
        bus.txfifo_full = 1'b0;
        next_cycle();
        next_cycle();
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_wr", 32'(bus.txfifo_wr), 0);
        check("rst_data", 32'(bus.txfifo_data), 0);
        check("rst_frame_count", 32'(bus.frame_count), 0);
        rst    = 1'b0;
        exp_fc = '0;

        // Table: arbitration order, space threshold and full gating, one frame each.
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            set_lanes(tab[i].code, tab[i].data);
            bus.req         = tab[i].req;
            bus.txfifo_load = tab[i].load;
            bus.txfifo_full = tab[i].full;
            lane = 0;
            for (int j = 0; j < NUM_REQ; j++) if (tab[i].exp_grant[j]) lane = j;
            if (tab[i].exp_grant != 0) push_frame(tab[i].code + 16'(lane), tab[i].data + 32'(lane), 8);
            next_cycle();
            check($sformatf("grant_v%0d", i), 32'(bus.grant), 32'(tab[i].exp_grant));
            if (tab[i].exp_grant != 0) begin
                check($sformatf("busy_v%0d", i), 32'(bus.busy), 1);
                bus.req = '0;
                next_cycle();
                check($sformatf("grant_pulse_v%0d", i), 32'(bus.grant), 0);
                wait_done(n);
                check($sformatf("done_latency_v%0d", i), 32'(n), 7);
                check($sformatf("busy_at_done_v%0d", i), 32'(bus.busy), 0);
                exp_fc = exp_fc + 16'd1;
                check($sformatf("frame_count_v%0d", i), 32'(bus.frame_count), 32'(exp_fc));
            end else begin
                check($sformatf("busy_v%0d", i), 32'(bus.busy), 0);
            end
        end
        bus.txfifo_load = '0;
        bus.txfifo_full = 1'b0;
        check("sb_empty_table", 32'(sb.size()), 0);

        // Round-robin: req[0] and req[2] held high from reset.
        reset_dut();
        exp_fc = '0;
        set_lanes(16'h0A00, 32'h000000A0);
        bus.req = 4'b0101;
        for (int g = 0; g < 4; g++) push_frame(16'h0A00 + 16'((g % 2) * 2), 32'h000000A0 + 32'((g % 2) * 2), 8);
        last_g = 0;
        for (int g = 0; g < 4; g++) begin
            w = 0;
            do begin
                next_cycle();
                w++;
            end while (bus.grant == '0 && w < 20);
            check($sformatf("rr_grant_%0d", g), 32'(bus.grant), (g % 2 == 0) ? 32'h1 : 32'h4);
            if (g > 0) check($sformatf("rr_gap_%0d", g), 32'(cyc - last_g), 9);
            last_g = cyc;
            if (g == 3) bus.req = '0;
        end
        wait_done(n);
        check("rr_last_done", 32'(n), 8);
        exp_fc = exp_fc + 16'd4;
        check("rr_frame_count", 32'(bus.frame_count), 32'(exp_fc));
        check("sb_empty_rr", 32'(sb.size()), 0);

        // Backpressure: full for 3 cycles while byte 3 is pending.
        next_cycle();
        set_lanes(16'hB00A, 32'h13579BDE);
        bus.req = 4'b0010;
        push_frame(16'hB00B, 32'h13579BDF, 8);
        next_cycle();
        check("bp_grant", 32'(bus.grant), 32'h2);
        bus.req = '0;
        next_cycle();
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bus.txfifo_full = 1'b1;
            #1;
            check("bp_no_write", 32'(bus.txfifo_wr), 0);
            check("bp_busy", 32'(bus.busy), 1);
            check("bp_pending", 32'(sb.size()), 5);
        end
        next_cycle();
        bus.txfifo_full = 1'b0;
        wait_done(n);
        check("bp_done_latency", 32'(n), 5);
        exp_fc = exp_fc + 16'd1;
        check("bp_frame_count", 32'(bus.frame_count), 32'(exp_fc));

        // Reset mid-frame after byte 4; req[3] stays pending through the reset.
        next_cycle();
        set_lanes(16'h3330, 32'h33333330);
        bus.req = 4'b1000;
        push_frame(16'h3333, 32'h33333333, 5);
        next_cycle();
        check("rstm_grant", 32'(bus.grant), 32'h8);
        for (int k = 0; k < 4; k++) next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        check("rstm_wr_assert", 32'(bus.txfifo_wr), 0);
        next_cycle();
        check("rstm_busy", 32'(bus.busy), 0);
        check("rstm_wr", 32'(bus.txfifo_wr), 0);
        check("rstm_done", 32'(bus.done), 0);
        check("rstm_frame_count", 32'(bus.frame_count), 0);
        check("rstm_sb_drained", 32'(sb.size()), 0);
        exp_fc = '0;
        push_frame(16'h3333, 32'h33333333, 8);
        rst = 1'b0;
        next_cycle();
        check("rstm_regrant", 32'(bus.grant), 32'h8);
        bus.req = '0;
        wait_done(n);
        check("rstm_done_latency", 32'(n), 8);
        exp_fc = exp_fc + 16'd1;
        check("rstm_frame_count_after", 32'(bus.frame_count), 32'(exp_fc));

        // Counter wrap: preload 0xFFFF while idle, then complete one frame.
        next_cycle();
        force dut.r_frame_count = 16'hFFFF;
        next_cycle();
        release dut.r_frame_count;
        next_cycle();
        exp_fc = 16'hFFFF;
        check("wrap_preload", 32'(bus.frame_count), 32'(exp_fc));
        set_lanes(16'h0123, 32'h89ABCDEF);
        bus.req = 4'b0001;
        push_frame(16'h0123, 32'h89ABCDEF, 8);
        next_cycle();
        check("wrap_grant", 32'(bus.grant), 32'h1);
        bus.req = '0;
        wait_done(n);
        exp_fc = exp_fc + 16'd1;
        check("wrap_frame_count", 32'(bus.frame_count), 32'(exp_fc));

        next_cycle();
        check("sb_empty_end", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
